// File: rtl/jpeg_cmd_pkg.sv
// rtl/jpeg_cmd_pkg.sv - opcodes, FSM states and error codes for the JPEG command scheduler
package jpeg_cmd_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_START = 4'd1;
    localparam logic [3:0] OP_ABORT = 4'd2;
    localparam logic [3:0] OP_CLR   = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_SRST  = 3'd3
    } sched_state_e;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_ILL  = 3'd1;
    localparam logic [2:0] ERR_STO  = 3'd2;
    localparam logic [2:0] ERR_RTO  = 3'd3;
    localparam logic [2:0] ERR_ENG  = 3'd4;
    localparam logic [2:0] ERR_OVR  = 3'd5;

endpackage

// File: rtl/jpeg_cmd_sched_if.sv
// rtl/jpeg_cmd_sched_if.sv - command register and decode engine handshake bundle
interface jpeg_cmd_sched_if;
    logic        cmd_int_req;
    logic [31:0] cmd_di;
    logic        cmd_clr;
    logic        eng_start;
    logic [23:0] eng_addr;
    logic        eng_srst;
    logic        eng_busy;
    logic        eng_done;
    logic        eng_err;

    modport master (
        input  cmd_int_req, cmd_di, eng_busy, eng_done, eng_err,
        output cmd_clr, eng_start, eng_addr, eng_srst
    );

    modport slave (
        output cmd_int_req, cmd_di, eng_busy, eng_done, eng_err,
        input  cmd_clr, eng_start, eng_addr, eng_srst
    );
endinterface

// File: rtl/sched_wdog.sv
// rtl/sched_wdog.sv - shared watchdog up-counter with clear and compare-to-limit
module sched_wdog #(
    parameter int unsigned TO_W = 24
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [TO_W-1:0] lim,
    output logic            hit
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    assign hit = (cnt == lim);

endmodule

// File: rtl/jpeg_cmd_sched.sv
// rtl/jpeg_cmd_sched.sv - command sequencer driving the JPEG decode engine
module jpeg_cmd_sched
    import jpeg_cmd_pkg::*;
#(
    parameter int unsigned     TO_W     = 24,
    parameter int unsigned     START_TO = 16,
    parameter logic [TO_W-1:0] RUN_TO   = 24'd10_000_000,
    parameter int unsigned     SRST_CYC = 8
) (
    input  logic              sys_clk,
    input  logic              rst,
    jpeg_cmd_sched_if.master  bus,
    output logic [2:0]        err_code,
    output logic [15:0]       done_cnt,
    output logic              irq,
    output logic [2:0]        sched_state
);

    sched_state_e    state;
    logic            cmd_vld;
    logic [3:0]      cmd_op;
    logic [23:0]     cmd_arg;
    logic            pend_vld;
    logic [23:0]     pend_addr;
    logic [TO_W-1:0] wd_lim;
    logic            wd_clr;
    logic            wd_hit;
    logic            run_hit;
    logic            abort_cmd;
    logic            start_cmd;
    logic            unused_rsvd;

    assign abort_cmd   = cmd_vld && (cmd_op == OP_ABORT);
    assign start_cmd   = cmd_vld && (cmd_op == OP_START);
    assign run_hit     = wd_hit && (RUN_TO != '0);
    assign sched_state = state;
    assign unused_rsvd = ^bus.cmd_di[27:24];

    always_comb begin
        wd_lim = '0;
        case (state)
            ST_START: wd_lim = TO_W'(START_TO - 1);
            ST_RUN:   wd_lim = RUN_TO - TO_W'(1);
            ST_SRST:  wd_lim = TO_W'(SRST_CYC - 1);
            default:  wd_lim = '0;
        endcase
    end

    // Counter must read 0 in the first cycle of every state, so clear it on each exit edge.
    always_comb begin
        wd_clr = (state == ST_IDLE) || wd_hit
              || ((state == ST_START) && bus.eng_busy)
              || ((state == ST_RUN) && (bus.eng_done || bus.eng_err || abort_cmd));
    end

    sched_wdog #(.TO_W(TO_W)) u_wdog (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (state != ST_IDLE),
        .lim     (wd_lim),
        .hit     (wd_hit)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cmd_vld       <= 1'b0;
            cmd_op        <= '0;
            cmd_arg       <= '0;
            pend_vld      <= 1'b0;
            pend_addr     <= '0;
            bus.cmd_clr   <= 1'b0;
            bus.eng_start <= 1'b0;
            bus.eng_addr  <= '0;
            bus.eng_srst  <= 1'b0;
            err_code      <= ERR_NONE;
            done_cnt      <= '0;
            irq           <= 1'b0;
        end else begin
            cmd_vld <= bus.cmd_int_req;
            if (bus.cmd_int_req) begin
                cmd_op  <= bus.cmd_di[31:28];
                cmd_arg <= bus.cmd_di[23:0];
            end
            bus.cmd_clr   <= 1'b0;
            bus.eng_start <= 1'b0;
            irq           <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cmd_vld) begin
                        case (cmd_op)
                            OP_NOP: bus.cmd_clr <= 1'b1;
                            OP_CLR: begin
                                err_code    <= ERR_NONE;
                                done_cnt    <= '0;
                                bus.cmd_clr <= 1'b1;
                            end
                            OP_START: begin
                                state         <= ST_START;
                                bus.eng_start <= 1'b1;
                                bus.eng_addr  <= cmd_arg;
                            end
                            OP_ABORT: begin
                                state        <= ST_SRST;
                                bus.eng_srst <= 1'b1;
                                bus.cmd_clr  <= 1'b1;
                            end
                            default: begin
                                if (err_code == ERR_NONE) err_code <= ERR_ILL;
                                irq         <= 1'b1;
                                bus.cmd_clr <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_START: begin
                    if (cmd_vld) begin
                        if (err_code == ERR_NONE) err_code <= ERR_OVR;
                        irq <= 1'b1;
                    end
                    if (bus.eng_busy) begin
                        state       <= ST_RUN;
                        bus.cmd_clr <= 1'b1;
                    end else if (wd_hit) begin
                        if (err_code == ERR_NONE) err_code <= ERR_STO;
                        irq         <= 1'b1;
                        bus.cmd_clr <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    if (bus.eng_done) begin
                        done_cnt <= done_cnt + 16'd1;
                        irq      <= 1'b1;
                    end
                    // In-place commands; a CLR here overrides the done increment above.
                    if (cmd_vld) begin
                        if (pend_vld && (cmd_op != OP_ABORT)) begin
                            if (err_code == ERR_NONE) err_code <= ERR_OVR;
                            irq <= 1'b1;
                        end else begin
                            case (cmd_op)
                                OP_NOP: bus.cmd_clr <= 1'b1;
                                OP_CLR: begin
                                    err_code    <= ERR_NONE;
                                    done_cnt    <= '0;
                                    bus.cmd_clr <= 1'b1;
                                end
                                OP_START, OP_ABORT: begin
                                end
                                default: begin
                                    if (err_code == ERR_NONE) err_code <= ERR_ILL;
                                    irq         <= 1'b1;
                                    bus.cmd_clr <= 1'b1;
                                end
                            endcase
                        end
                    end
                    if (bus.eng_err) begin
                        if (err_code == ERR_NONE) err_code <= ERR_ENG;
                        irq          <= 1'b1;
                        state        <= ST_SRST;
                        bus.eng_srst <= 1'b1;
                        pend_vld     <= 1'b0;
                        bus.cmd_clr  <= pend_vld || start_cmd;
                    end else if (abort_cmd) begin
                        state        <= ST_SRST;
                        bus.eng_srst <= 1'b1;
                        pend_vld     <= 1'b0;
                        bus.cmd_clr  <= 1'b1;
                    end else if (bus.eng_done) begin
                        if (pend_vld) begin
                            state         <= ST_START;
                            bus.eng_start <= 1'b1;
                            bus.eng_addr  <= pend_addr;
                            pend_vld      <= 1'b0;
                        end else if (start_cmd) begin
                            state         <= ST_START;
                            bus.eng_start <= 1'b1;
                            bus.eng_addr  <= cmd_arg;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (run_hit) begin
                        if (err_code == ERR_NONE) err_code <= ERR_RTO;
                        irq          <= 1'b1;
                        state        <= ST_SRST;
                        bus.eng_srst <= 1'b1;
                        pend_vld     <= 1'b0;
                        bus.cmd_clr  <= pend_vld || start_cmd;
                    end else if (start_cmd && !pend_vld) begin
                        pend_vld  <= 1'b1;
                        pend_addr <= cmd_arg;
                    end
                end

                ST_SRST: begin
                    if (cmd_vld) begin
                        if (err_code == ERR_NONE) err_code <= ERR_OVR;
                        irq <= 1'b1;
                    end
                    if (wd_hit) begin
                        state        <= ST_IDLE;
                        bus.eng_srst <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_cmd_sched.sv
// tb/tb_jpeg_cmd_sched.sv - directed vector bench for jpeg_cmd_sched
module tb_jpeg_cmd_sched;

    logic        sys_clk;
    logic        rst;
    logic [2:0]  err_code;
    logic [15:0] done_cnt;
    logic        irq;
    logic [2:0]  sched_state;

    int nvec;
    int nerr;

    jpeg_cmd_sched_if bus ();

    jpeg_cmd_sched #(
        .TO_W     (24),
        .START_TO (16),
        .RUN_TO   (24'd10_000_000),
        .SRST_CYC (8)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .bus         (bus),
        .err_code    (err_code),
        .done_cnt    (done_cnt),
        .irq         (irq),
        .sched_state (sched_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] cmd;
        logic        exp_clr;
        logic        exp_irq;
        logic [2:0]  exp_err;
    } vec_t;

    vec_t vtab[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send(input logic [31:0] cmd);
        bus.cmd_int_req = 1'b1;
        bus.cmd_di      = cmd;
        cyc(1);
        bus.cmd_int_req = 1'b0;
    endtask

    task automatic run_start(input logic [23:0] addr);
        send({8'h10, addr});
        cyc(1);
        bus.eng_busy = 1'b1;
        cyc(1);
        check("run_start_state", 32'(sched_state), 32'd2);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cmd_clr"}, 32'(bus.cmd_clr), 32'd0);
        check({tag, "_eng_start"}, 32'(bus.eng_start), 32'd0);
        check({tag, "_eng_addr"}, 32'(bus.eng_addr), 32'd0);
        check({tag, "_eng_srst"}, 32'(bus.eng_srst), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd0);
        check({tag, "_irq"}, 32'(irq), 32'd0);
        check({tag, "_state"}, 32'(sched_state), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        nvec = 0;
        nerr = 0;
        vtab[0] = '{32'h0000_0000, 1'b1, 1'b0, 3'd0};
        vtab[1] = '{32'h7000_0000, 1'b1, 1'b1, 3'd1};
        vtab[2] = '{32'hF000_0000, 1'b1, 1'b1, 3'd1};
        vtab[3] = '{32'h3000_0000, 1'b1, 1'b0, 3'd0};
        vtab[4] = '{32'h4000_0001, 1'b1, 1'b1, 3'd1};
        vtab[5] = '{32'h3000_0000, 1'b1, 1'b0, 3'd0};

        rst             = 1'b1;
        bus.cmd_int_req = 1'b0;
        bus.cmd_di      = '0;
        bus.eng_busy    = 1'b0;
        bus.eng_done    = 1'b0;
        bus.eng_err     = 1'b0;
        cyc(3);
        check_zero("reset");
        rst = 1'b0;
        cyc(1);

        for (int i = 0; i < 6; i++) begin
            send(vtab[i].cmd);
            cyc(1);
            check($sformatf("vec%0d_clr", i), 32'(bus.cmd_clr), 32'(vtab[i].exp_clr));
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vtab[i].exp_irq));
            check($sformatf("vec%0d_err", i), 32'(err_code), 32'(vtab[i].exp_err));
            check($sformatf("vec%0d_state", i), 32'(sched_state), 32'd0);
            cyc(1);
        end

        // START with busy 3 cycles after eng_start, then done
        send(32'h1000_1234);
        cyc(1);
        check("start_pulse", 32'(bus.eng_start), 32'd1);
        check("start_addr", 32'(bus.eng_addr), 32'h0000_1234);
        check("start_state", 32'(sched_state), 32'd1);
        cyc(3);
        check("start_noclr", 32'(bus.cmd_clr), 32'd0);
        bus.eng_busy = 1'b1;
        cyc(1);
        check("start_clr", 32'(bus.cmd_clr), 32'd1);
        check("start_run", 32'(sched_state), 32'd2);
        cyc(2);
        bus.eng_done = 1'b1;
        bus.eng_busy = 1'b0;
        cyc(1);
        bus.eng_done = 1'b0;
        check("done_cnt1", 32'(done_cnt), 32'd1);
        check("done_irq", 32'(irq), 32'd1);
        check("done_idle", 32'(sched_state), 32'd0);

        // Pending START launched on done
        cyc(1);
        run_start(24'h000111);
        send(32'h1000_0ABC);
        cyc(1);
        check("pend_noclr0", 32'(bus.cmd_clr), 32'd0);
        cyc(1);
        check("pend_noclr1", 32'(bus.cmd_clr), 32'd0);
        bus.eng_done = 1'b1;
        bus.eng_busy = 1'b0;
        cyc(1);
        bus.eng_done = 1'b0;
        check("pend_start", 32'(bus.eng_start), 32'd1);
        check("pend_addr", 32'(bus.eng_addr), 32'h0000_0ABC);
        check("pend_state", 32'(sched_state), 32'd1);
        check("pend_done_cnt", 32'(done_cnt), 32'd2);
        bus.eng_busy = 1'b1;
        cyc(1);
        check("pend_clr", 32'(bus.cmd_clr), 32'd1);
        bus.eng_done = 1'b1;
        bus.eng_busy = 1'b0;
        cyc(1);
        bus.eng_done = 1'b0;
        check("pend_done_cnt3", 32'(done_cnt), 32'd3);
        check("pend_idle", 32'(sched_state), 32'd0);

        // Start timeout: cmd_clr exactly START_TO cycles after eng_start
        cyc(1);
        send(32'h1000_0055);
        cyc(1);
        check("sto_start", 32'(bus.eng_start), 32'd1);
        n = 0;
        for (k = 1; k <= 40; k++) begin
            cyc(1);
            if (bus.cmd_clr) begin
                n = k;
                break;
            end
        end
        check("sto_cycles", 32'(n), 32'd16);
        check("sto_err", 32'(err_code), 32'd2);
        check("sto_irq", 32'(irq), 32'd1);
        check("sto_idle", 32'(sched_state), 32'd0);

        // ABORT during run
        cyc(1);
        send(32'h3000_0000);
        cyc(1);
        check("clr_err", 32'(err_code), 32'd0);
        check("clr_done", 32'(done_cnt), 32'd0);
        cyc(1);
        run_start(24'h000222);
        send(32'h2000_0000);
        cyc(1);
        check("abort_clr", 32'(bus.cmd_clr), 32'd1);
        check("abort_state", 32'(sched_state), 32'd3);
        bus.eng_busy = 1'b0;
        n = 0;
        for (k = 0; k < 30; k++) begin
            if (!bus.eng_srst) break;
            n++;
            cyc(1);
        end
        check("abort_srst_len", 32'(n), 32'd8);
        check("abort_idle", 32'(sched_state), 32'd0);
        bus.eng_done = 1'b1;
        cyc(1);
        bus.eng_done = 1'b0;
        cyc(1);
        check("abort_stray_done", 32'(done_cnt), 32'd0);

        // Sticky first error, irq on later errors, CLR_STAT
        send(32'h7000_0000);
        cyc(1);
        check("ill_err", 32'(err_code), 32'd1);
        cyc(1);
        run_start(24'h000333);
        bus.eng_err = 1'b1;
        cyc(1);
        bus.eng_err = 1'b0;
        bus.eng_busy = 1'b0;
        check("engerr_sticky", 32'(err_code), 32'd1);
        check("engerr_irq", 32'(irq), 32'd1);
        check("engerr_srst", 32'(sched_state), 32'd3);
        cyc(10);
        run_start(24'h000444);
        bus.eng_done = 1'b1;
        bus.eng_busy = 1'b0;
        cyc(1);
        bus.eng_done = 1'b0;
        check("pre_clr_done", 32'(done_cnt), 32'd1);
        send(32'h3000_0000);
        cyc(1);
        check("clrstat_err", 32'(err_code), 32'd0);
        check("clrstat_done", 32'(done_cnt), 32'd0);
        cyc(1);

        // Overrun, then eng_err with a pending START, then reset inside ST_SRST
        run_start(24'h000555);
        send(32'h1000_0666);
        cyc(1);
        send(32'h1000_0777);
        cyc(1);
        check("ovr_err", 32'(err_code), 32'd5);
        check("ovr_irq", 32'(irq), 32'd1);
        check("ovr_noclr", 32'(bus.cmd_clr), 32'd0);
        bus.eng_err = 1'b1;
        cyc(1);
        bus.eng_err = 1'b0;
        bus.eng_busy = 1'b0;
        check("ovr_srst_state", 32'(sched_state), 32'd3);
        check("ovr_srst_clr", 32'(bus.cmd_clr), 32'd1);
        check("ovr_srst_level", 32'(bus.eng_srst), 32'd1);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        check_zero("midrst");
        rst = 1'b0;
        n = 0;
        for (k = 0; k < 12; k++) begin
            cyc(1);
            if (bus.cmd_clr || bus.eng_srst) n++;
        end
        check("midrst_quiet", 32'(n), 32'd0);
        check("midrst_idle", 32'(sched_state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
